// File: rtl/imem_loader.sv
// Boot loader: streams a program image into instruction memory,
// holding the core in reset until the image is complete.
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned STRIDE    = 4,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic [31:0]   mem_address,
  output logic          mem_write_enable,
  output logic [31:0]   mem_write_data,
  output logic          mem_read_enable,
  output logic          cpu_reset_n,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] word_count,
  output logic [31:0]   checksum
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  localparam logic [CW-1:0] MAXW = CW'(DEPTH);
  localparam logic [31:0]   STEP = 32'(STRIDE);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] wr_ptr;
  logic        accept;
  logic        room;
  logic        wr;
  logic        clr;

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign room     = (word_count < MAXW);
  assign wr       = accept && room;

  // A new load may only begin from a quiescent state.
  assign clr = start && (state_q == IDLE ||
                         state_q == DONE ||
                         state_q == ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (!room)       state_d = ERROR;
          else if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE, ERROR: begin
        if (start) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // wr_ptr tracks the next write address so no multiplier is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_write_enable <= 1'b0;
      mem_address      <= 32'h0;
      mem_write_data   <= 32'h0;
      word_count       <= '0;
      checksum         <= 32'h0;
      wr_ptr           <= BASE_ADDR;
    end else begin
      mem_write_enable <= wr;
      if (clr) begin
        word_count <= '0;
        checksum   <= 32'h0;
        wr_ptr     <= BASE_ADDR;
      end else if (wr) begin
        mem_address    <= wr_ptr;
        mem_write_data <= in_data;
        wr_ptr         <= wr_ptr + STEP;
        word_count     <= word_count + 1'b1;
        checksum       <= checksum + in_data;
      end
    end
  end

  assign done            = (state_q == DONE);
  assign error           = (state_q == ERROR);
  assign cpu_reset_n     = done;
  assign mem_read_enable = 1'b0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: main image loads, gaps,
// overflow on a DEPTH=4 copy, mid-load reset and reload.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_read_enable;
  logic        cpu_reset_n;
  logic        done;
  logic        error;
  logic [10:0] word_count;
  logic [31:0] checksum;

  logic        s4;
  logic        v4;
  logic [31:0] d4;
  logic        l4;
  logic        rdy4;
  logic [31:0] a4;
  logic        we4;
  logic [31:0] wd4;
  logic        re4;
  logic        crn4;
  logic        done4;
  logic        err4;
  logic [2:0]  wc4;
  logic [31:0] cs4;

  int n_cmp = 0;
  int n_err = 0;
  int n_str4 = 0;

  logic [31:0] mem [0:15];
  logic [31:0] img [0:2];
  logic [31:0] sum;

  always #5 clock = ~clock;

  imem_loader u_dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .mem_address(mem_address),
    .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data),
    .mem_read_enable(mem_read_enable),
    .cpu_reset_n(cpu_reset_n),
    .done(done),
    .error(error),
    .word_count(word_count),
    .checksum(checksum)
  );

  imem_loader #(.DEPTH(4)) u_d4 (
    .clock(clock),
    .reset(reset),
    .start(s4),
    .in_valid(v4),
    .in_data(d4),
    .in_last(l4),
    .in_ready(rdy4),
    .mem_address(a4),
    .mem_write_enable(we4),
    .mem_write_data(wd4),
    .mem_read_enable(re4),
    .cpu_reset_n(crn4),
    .done(done4),
    .error(err4),
    .word_count(wc4),
    .checksum(cs4)
  );

  // Memory model latches on the negedge inside the strobe cycle.
  always @(negedge clock) begin
    if (mem_write_enable && mem_address[31:6] == 26'h0)
      mem[mem_address[5:2]] <= mem_write_data;
    if (we4)
      n_str4 <= n_str4 + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    img[0] = 32'h20080005;
    img[1] = 32'h2009000A;
    img[2] = 32'h01095020;
    sum = img[0] + img[1] + img[2];
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_last = 1'b0;
    s4 = 1'b0;
    v4 = 1'b0;
    d4 = 32'h0;
    l4 = 1'b0;

    // 1: reset
    tick();
    tick();
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_data", mem_write_data, 32'h0);
    check("rst_re", 32'(mem_read_enable), 32'd0);
    check("rst_crn", 32'(cpu_reset_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_cs", checksum, 32'h0);
    reset = 1'b0;
    tick();

    // start with in_valid high in IDLE: no word taken
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    pulse_start();
    in_valid = 1'b0;
    check("idle_nowe", 32'(mem_write_enable), 32'd0);
    check("idle_wc", 32'(word_count), 32'd0);

    // 2: back-to-back image
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = img[i];
      in_last = (i == 2);
      tick();
      check($sformatf("b2b_we%0d", i), 32'(mem_write_enable), 32'd1);
      check($sformatf("b2b_a%0d", i), mem_address, 32'(i * 4));
      check($sformatf("b2b_d%0d", i), mem_write_data, img[i]);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    tick();
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_crn", 32'(cpu_reset_n), 32'd1);
    check("b2b_we_off", 32'(mem_write_enable), 32'd0);
    check("b2b_wc", 32'(word_count), 32'd3);
    check("b2b_cs", checksum, sum);
    check("b2b_cs_k", checksum, 32'h411A502F);

    // 6: start in DONE clears and drops the core back into reset
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    pulse_start();
    check("rs_crn", 32'(cpu_reset_n), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_wc", 32'(word_count), 32'd0);
    check("rs_cs", checksum, 32'h0);

    // 3: same image with gaps
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      tick();
      check($sformatf("gap_nowe%0d", i), 32'(mem_write_enable), 32'd0);
      in_valid = 1'b1;
      in_data = img[i];
      in_last = (i == 2);
      tick();
      check($sformatf("gap_we%0d", i), 32'(mem_write_enable), 32'd1);
      check($sformatf("gap_a%0d", i), mem_address, 32'(i * 4));
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    tick();
    check("gap_done", 32'(done), 32'd1);
    check("gap_wc", 32'(word_count), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("gap_mem%0d", i), mem[i], img[i]);

    // 4: overflow on DEPTH=4 instance
    s4 = 1'b1;
    tick();
    s4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v4 = 1'b1;
      d4 = 32'(i + 1);
      tick();
    end
    v4 = 1'b0;
    check("ovf_err", 32'(err4), 32'd1);
    check("ovf_done", 32'(done4), 32'd0);
    check("ovf_crn", 32'(crn4), 32'd0);
    check("ovf_rdy", 32'(rdy4), 32'd0);
    check("ovf_we", 32'(we4), 32'd0);
    check("ovf_wc", 32'(wc4), 32'd4);
    check("ovf_cs", cs4, 32'd10);
    tick();
    check("ovf_strobes", 32'(n_str4), 32'd4);
    check("ovf_hold", 32'(err4), 32'd1);

    // 5: reset after two accepted words
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = img[i];
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_we", 32'(mem_write_enable), 32'd0);
    check("mrst_addr", mem_address, 32'h0);
    check("mrst_data", mem_write_data, 32'h0);
    check("mrst_wc", 32'(word_count), 32'd0);
    check("mrst_cs", checksum, 32'h0);
    check("mrst_rdy", 32'(in_ready), 32'd0);
    check("mrst_crn", 32'(cpu_reset_n), 32'd0);
    pulse_start();
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    check("mrst_a", mem_address, 32'h0);
    check("mrst_d", mem_write_data, 32'hDEADBEEF);
    tick();
    check("mrst_wc1", 32'(word_count), 32'd1);
    check("mrst_done", 32'(done), 32'd1);
    check("mrst_mem0", mem[0], 32'hDEADBEEF);

    // 6b: reload from DONE overwrites at base
    pulse_start();
    check("rl_wc0", 32'(word_count), 32'd0);
    in_valid = 1'b1;
    in_data = 32'h12345678;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    check("rl_a", mem_address, 32'h0);
    tick();
    check("rl_mem0", mem[0], 32'h12345678);
    check("rl_cs", checksum, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
